// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame layout constants and the running-checksum helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Frame checksum is a plain XOR over every byte before the CSUM byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_word_asm.sv
// Byte-to-word assembler: collects bytes LSB first and flags the cycle in which
// the last byte of a word arrives, presenting the complete word combinationally.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] IDX_LAST = 2'(WORD_BYTES - 1);

    logic [1:0]  byte_idx_q;
    logic [1:0]  byte_idx_d;
    logic [23:0] shreg_q;
    logic [23:0] shreg_d;

    // Next-state for byte index and the three lower bytes of the word
    always_comb begin
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        if (byte_en_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    shreg_d[7:0]   = byte_i;
                2'd1:    shreg_d[15:8]  = byte_i;
                2'd2:    shreg_d[23:16] = byte_i;
                default: shreg_d        = shreg_q;
            endcase
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Assembler state; reset discards any partially collected word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= 2'd0;
            shreg_q    <= 24'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
        end
    end

    // The top byte bypasses the register so the word is complete on its last byte
    always_comb begin
        word_o       = {byte_i, shreg_q};
        word_ready_o = byte_en_i && (byte_idx_q == IDX_LAST);
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and keeps the core in reset until the whole image has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_e      state_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [7:0]  csum_q;
    logic        ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        core_rst_q;
    logic        done_q;
    logic        err_q;

    logic        xfer_s;
    logic        asm_en_s;
    logic        in_frame_s;
    logic [15:0] len_full_s;
    logic        len_big_s;
    logic        last_word_s;
    logic [31:0] word_s;
    logic        word_rdy_s;

    // Handshake qualifiers and length decode
    always_comb begin
        xfer_s      = byte_valid && ready_q;
        asm_en_s    = xfer_s && (state_q == S_DATA);
        in_frame_s  = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
        len_full_s  = {byte_data, len_q[7:0]};
        len_big_s   = {1'b0, len_full_s} > DEPTH_W;
        last_word_s = (word_idx_q == (len_q - 16'd1));
    end

    imem_word_asm u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_en_i    (asm_en_s),
        .byte_i       (byte_data),
        .word_o       (word_s),
        .word_ready_o (word_rdy_s)
    );

    // Frame FSM with write port, counters, checksum and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LEN0;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            csum_q     <= 8'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Write issues one cycle after the 4th byte, independent of FSM progress
            we_q <= 1'b0;
            if (word_rdy_s) begin
                we_q       <= 1'b1;
                wdata_q    <= word_s;
                addr_q     <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                word_idx_q <= word_idx_q + 16'd1;
            end
            if (xfer_s && in_frame_s) begin
                csum_q <= csum_update(csum_q, byte_data);
            end
            case (state_q)
                S_LEN0: begin
                    ready_q <= 1'b1;
                    if (xfer_s) begin
                        len_q[7:0] <= byte_data;
                        state_q    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer_s) begin
                        len_q[15:8] <= byte_data;
                        if (len_big_s) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (len_full_s == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_rdy_s && last_word_s) begin
                        state_q <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (xfer_s) begin
                        ready_q <= 1'b0;
                        if (byte_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    ready_q    <= 1'b0;
                    done_q     <= 1'b1;
                    core_rst_q <= 1'b1;
                end
                S_ERR: begin
                    ready_q    <= 1'b0;
                    err_q      <= 1'b1;
                    core_rst_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_ERR;
                    ready_q    <= 1'b0;
                    err_q      <= 1'b1;
                    core_rst_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
